// File: rtl/kuz_decrypt_core_if.sv
// Block-level bus of the Grasshopper decryptor: ciphertext in, plaintext out,
// plus the zero-latency round-key lookup towards the external key store.
interface kuz_decrypt_core_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] data_i;
  logic [3:0]   key_sel_o;
  logic [127:0] round_key_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] data_o;
  logic         busy_o;

  modport slave (
    input  in_valid_i, data_i, round_key_i, out_ready_i,
    output in_ready_o, key_sel_o, out_valid_o, data_o, busy_o
  );

  modport master (
    output in_valid_i, data_i, round_key_i, out_ready_i,
    input  in_ready_o, key_sel_o, out_valid_o, data_o, busy_o
  );
endinterface

// File: rtl/kuz_decrypt_core.sv
// Iterative Grasshopper (GOST R 34.12-2015) block decryptor: X[K10], then nine
// rounds of L^-1 (16 serial R^-1 steps), S^-1 and X[Ki], one block at a time.
module kuz_decrypt_core #(
  parameter int NROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  kuz_decrypt_core_if.slave bus
);
  typedef logic [7:0]        byte_t;
  typedef logic [255:0][7:0] tbl_t;
  typedef enum logic [2:0] {IDLE, LINV, SINV, KXOR, DONE} state_t;

  localparam logic [3:0] KEY_FIRST   = 4'(NROUNDS - 1);
  localparam logic [3:0] ROUND_START = 4'(NROUNDS - 2);

  localparam byte_t PI [256] = '{
    252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
    233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
    249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
      5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
    235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
    181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
     21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
     50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
    223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
    224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
    167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
    173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
      7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
    225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
     32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
     89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
  };

  // Linear-map coefficient for byte position 0..15 of the (rotated) argument.
  localparam byte_t LCOEF [16] = '{
    1, 148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148
  };

  // The inverse S-box is derived from the forward table at elaboration time.
  function automatic tbl_t invert_pi();
    tbl_t t;
    t = '0;
    for (int i = 0; i < 256; i++) t[PI[i]] = 8'(i);
    return t;
  endfunction

  localparam tbl_t PI_INV = invert_pi();

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
    end
    return p;
  endfunction

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;

  logic         in_ready;
  logic [127:0] rot_st;
  logic [127:0] rinv_st;
  logic [127:0] sinv_st;
  byte_t        lin_prod [16];
  byte_t        lin_sum;

  // R^-1 feeds l with (a14..a0, a15): a byte-rotate left of the state.
  assign rot_st = {st_q[119:0], st_q[127:120]};

  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign lin_prod[gi]         = gf_mul(rot_st[gi*8 +: 8], LCOEF[gi]);
    assign sinv_st[gi*8 +: 8]   = PI_INV[st_q[gi*8 +: 8]];
  end

  always_comb begin
    lin_sum = '0;
    for (int i = 0; i < 16; i++) lin_sum = lin_sum ^ lin_prod[i];
  end

  assign rinv_st = {st_q[119:0], lin_sum};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      round_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      round_q     <= round_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    round_d     = round_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid_i && in_ready) begin
          st_d    = bus.data_i ^ bus.round_key_i;
          round_d = ROUND_START;
          cnt_d   = '0;
          state_d = LINV;
        end
      end
      LINV: begin
        st_d  = rinv_st;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          cnt_d   = '0;
          state_d = SINV;
        end
      end
      SINV: begin
        st_d    = sinv_st;
        state_d = KXOR;
      end
      KXOR: begin
        st_d = st_q ^ bus.round_key_i;
        if (round_q == 4'd0) begin
          state_d = DONE;
        end else begin
          round_d = round_q - 4'd1;
          state_d = LINV;
        end
      end
      DONE: begin
        // Valid is registered, so it rises one cycle after DONE is entered.
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready        = rst && (state_q == IDLE);
  assign bus.in_ready_o  = in_ready;
  assign bus.key_sel_o   = (state_q == IDLE) ? KEY_FIRST : round_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.data_o      = st_q;
  assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_kuz_decrypt_core.sv
// Self-checking bench for kuz_decrypt_core: expected plaintexts come from a
// forward-cipher reference model (encrypt random plaintext, decrypt with DUT).
module tb_kuz_decrypt_core;
  logic clk = 1'b0;
  logic rst;

  kuz_decrypt_core_if bus();

  kuz_decrypt_core #(.NROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] MASTER_KEY =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] KAT_CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] KAT_PT  = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] SPEC_K1  = 128'h8899aabbccddeeff0011223344556677;
  localparam logic [127:0] SPEC_K10 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
  localparam int LATENCY = 163;
  localparam int NV = 6;

  localparam logic [7:0] PI [256] = '{
    252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
    233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
    249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
      5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
    235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
    181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
     21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
     50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
    223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
    224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
    167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
    173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
      7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
    225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
     32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
     89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
  };

  // Coefficients listed for byte positions 15 down to 0.
  localparam logic [7:0] LC [16] = '{
    148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1
  };

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           bp;
  } vec_t;

  logic [127:0] gold [10];
  logic [127:0] key_mem [16];
  vec_t         vecs [NV];
  int           pass_cnt = 0;
  int           total_cnt = 0;

  assign bus.round_key_i = key_mem[bus.key_sel_o];

  // ---------------- reference model (forward cipher) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc;
    acc = 0;
    for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--) if (acc[i]) acc = acc ^ (32'h1C3 << (i - 8));
    return acc[7:0];
  endfunction

  function automatic logic [127:0] l_step(input logic [127:0] v);
    logic [7:0] x;
    x = '0;
    for (int p = 0; p < 16; p++) x = x ^ gmul(v[8*p +: 8], LC[15 - p]);
    return {x, v[127:8]};
  endfunction

  function automatic logic [127:0] l_fwd(input logic [127:0] v);
    logic [127:0] r;
    r = v;
    for (int i = 0; i < 16; i++) r = l_step(r);
    return r;
  endfunction

  function automatic logic [127:0] s_fwd(input logic [127:0] v);
    logic [127:0] r;
    for (int p = 0; p < 16; p++) r[8*p +: 8] = PI[v[8*p +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int i = 0; i < 9; i++) s = l_fwd(s_fwd(s ^ gold[i]));
    return s ^ gold[9];
  endfunction

  task automatic expand_key(input logic [255:0] k);
    logic [127:0] a1, a0, t, c;
    a1 = k[255:128];
    a0 = k[127:0];
    gold[0] = a1;
    gold[1] = a0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 1; j <= 8; j++) begin
        c  = l_fwd(128'(8 * i + j));
        t  = l_fwd(s_fwd(a1 ^ c)) ^ a0;
        a0 = a1;
        a1 = t;
      end
      gold[2 + 2*i] = a1;
      gold[3 + 2*i] = a0;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic accept_only(input logic [127:0] ct);
    int k;
    k = 0;
    while (!bus.in_ready_o && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 128'(bus.in_ready_o), 128'd1);
    check("key_sel_accept", 128'(bus.key_sel_o), 128'd9);
    bus.in_valid_i = 1'b1;
    bus.data_i     = ct;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.data_i     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.out_ready_i = 1'b1;
    while (bus.busy_o && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("drain_idle", 128'(bus.busy_o), 128'd0);
    bus.out_ready_i = 1'b0;
  endtask

  // Runs one block; k counts negedges after the accepting edge.
  task automatic run_block(input logic [127:0] ct, input int bp, input bit noise,
                           output logic [127:0] got, output int lat);
    int  k;
    int  bad;
    bit  seen;
    accept_only(ct);
    k    = 0;
    seen = 1'b0;
    lat  = -1;
    got  = '0;
    while (k < 400 && !seen) begin
      if (k >= 17 && k <= 161 && ((k - 17) % 18) == 0)
        check("key_sel_round", 128'(bus.key_sel_o), 128'(8 - (k - 17) / 18));
      if (k == 40) begin
        check("in_ready_busy", 128'(bus.in_ready_o), 128'd0);
        check("busy_mid", 128'(bus.busy_o), 128'd1);
      end
      if (bus.out_valid_o) begin
        seen = 1'b1;
        lat  = k;
        got  = bus.data_o;
      end else begin
        if (noise && k < 150) begin
          bus.in_valid_i = 1'($urandom_range(0, 1));
          bus.data_i     = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          bus.in_valid_i = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    bus.in_valid_i = 1'b0;
    check("latency", 128'(lat), 128'(LATENCY));
    bad = 0;
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      if (bus.data_o !== got || bus.out_valid_o !== 1'b1 ||
          bus.in_ready_o !== 1'b0 || bus.busy_o !== 1'b1) bad++;
    end
    if (bp > 0) check("backpressure_hold", 128'(bad), 128'd0);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    check("release_valid", 128'(bus.out_valid_o), 128'd0);
    check("release_busy", 128'(bus.busy_o), 128'd0);
    check("release_ready", 128'(bus.in_ready_o), 128'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] got;
    logic [127:0] pt;
    int           lat;
    int           nv;

    bus.in_valid_i  = 1'b0;
    bus.data_i      = '0;
    bus.out_ready_i = 1'b0;
    rst             = 1'b0;

    expand_key(MASTER_KEY);
    for (int i = 0; i < 16; i++) key_mem[i] = (i < 10) ? gold[i] : '0;
    check("model_k1", gold[0], SPEC_K1);
    check("model_k10", gold[9], SPEC_K10);
    check("model_kat", encrypt(KAT_PT), KAT_CT);
    check("model_l", l_fwd(128'h64a59400000000000000000000000000),
          128'hd456584dd0e3e84cc3166e4b7fa2890d);

    #3;
    check("reset_valid", 128'(bus.out_valid_o), 128'd0);
    check("reset_busy", 128'(bus.busy_o), 128'd0);
    check("reset_data", bus.data_o, 128'd0);
    check("reset_ready_low", 128'(bus.in_ready_o), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 128'(bus.in_ready_o), 128'd1);
    check("idle_key_sel", 128'(bus.key_sel_o), 128'd9);

    // Vector table: the KAT block with long backpressure, then random blocks.
    vecs[0] = '{ct: KAT_CT, pt: KAT_PT, bp: 50};
    for (int i = 1; i < NV; i++) begin
      pt      = {$urandom, $urandom, $urandom, $urandom};
      vecs[i] = '{ct: encrypt(pt), pt: pt, bp: int'($urandom_range(0, 3))};
    end
    for (int i = 0; i < NV; i++) begin
      run_block(vecs[i].ct, vecs[i].bp, (i % 2) == 1, got, lat);
      check("table_pt", got, vecs[i].pt);
      $display("block %0d ct=%h pt=%h lat=%0d bp=%0d", i, vecs[i].ct, got, lat, vecs[i].bp);
    end

    // Inverse-primitive probes with K10 forced to zero.
    key_mem[9] = '0;
    accept_only(128'hd456584dd0e3e84cc3166e4b7fa2890d);
    repeat (16) @(negedge clk);
    check("linv_probe", bus.data_o, 128'h64a59400000000000000000000000000);
    $display("probe linv st=%h", bus.data_o);
    drain();
    accept_only(l_fwd(128'hb66cd8887d38e8d77765aeea0c9a7efc));
    repeat (17) @(negedge clk);
    check("sinv_probe", bus.data_o, 128'hffeeddccbbaa99881122334455667700);
    $display("probe sinv st=%h", bus.data_o);
    drain();
    key_mem[9] = gold[9];

    // Back-to-back with in_valid_i held high throughout.
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.data_i      = KAT_CT;
    @(negedge clk);
    bus.data_i = vecs[1].ct;
    nv = 0;
    for (int k = 0; k < 400 && nv < 2; k++) begin
      if (bus.out_valid_o) begin
        if (nv == 0) begin
          check("b2b_first_lat", 128'(k), 128'(LATENCY));
          check("b2b_first_pt", bus.data_o, KAT_PT);
        end else begin
          check("b2b_second_lat", 128'(k), 128'(2 * LATENCY + 2));
          check("b2b_second_pt", bus.data_o, vecs[1].pt);
          bus.in_valid_i = 1'b0;
        end
        $display("b2b out %0d at cycle %0d pt=%h", nv, k, bus.data_o);
        nv++;
      end
      if (nv < 2) @(negedge clk);
    end
    check("b2b_count", 128'(nv), 128'd2);
    bus.in_valid_i = 1'b0;
    drain();

    // Asynchronous reset in the middle of a block.
    accept_only(KAT_CT);
    repeat (80) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", 128'(bus.out_valid_o), 128'd0);
    check("midrst_busy", 128'(bus.busy_o), 128'd0);
    check("midrst_data", bus.data_o, 128'd0);
    check("midrst_ready", 128'(bus.in_ready_o), 128'd0);
    check("midrst_key_sel", 128'(bus.key_sel_o), 128'd9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_block(KAT_CT, 0, 1'b0, got, lat);
    check("post_reset_pt", got, KAT_PT);
    $display("post-reset block pt=%h lat=%0d", got, lat);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/kuz_decrypt_core.md
Name: kuz_decrypt_core

Overview:
- Iterative Grasshopper (GOST R 34.12-2015) block decryptor; the inverse-direction counterpart to the encoder round datapath (key_xor / linear / non_linear).
- Applies X[K10], then nine rounds of L^-1, S^-1, X[Ki] (i = 9 down to 1) to a 128-bit ciphertext block.
- Sits between the ciphertext input stream and the plaintext output.
- Round keys come from an external key store via an index/data lookup with zero-cycle response.

Parameters:
- NROUNDS, 10, number of round keys; K1..K10 map to key index 0..9.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  ciphertext block valid.
- in_ready_o  output  1  core can accept a block.
- data_i  input  128  ciphertext; byte 15 = [127:120].
- key_sel_o  output  4  round-key index requested this cycle.
- round_key_i  input  128  key store output for key_sel_o, same cycle (combinational).
- out_valid_o  output  1  plaintext valid.
- out_ready_i  input  1  downstream accepts plaintext.
- data_o  output  128  plaintext, driven from the state register.
- busy_o  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst low, asynchronous) values:
  - FSM = IDLE; state reg, data_o = 0; round = 0; cnt = 0.
  - out_valid_o = 0; busy_o = 0; in_ready_o = 1 once rst is high.
- Reset mid-operation aborts the block immediately; no partial output; next block starts clean.
- FSM states: IDLE, LINV, SINV, KXOR, DONE.
- IDLE:
  - key_sel_o = 9; in_ready_o = 1.
  - On in_valid_i & in_ready_o: st <= data_i ^ round_key_i; round <= 8; cnt <= 0; go to LINV.
- LINV (16 cycles):
  - Each cycle st <= R^-1(st); cnt increments.
  - At cnt == 15: cnt <= 0; go to SINV.
  - R^-1(a15..a0) = a14..a0 || l(a14,..,a0,a15).
  - l = GF(2^8) sum of coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1 applied to byte positions 15..0 of the argument.
  - GF(2^8) reduction polynomial 0x1C3.
  - Result byte enters at position 0.
- SINV (1 cycle): every byte replaced by the inverse pi table; go to KXOR.
- KXOR (1 cycle):
  - key_sel_o = round; st <= st ^ round_key_i.
  - If round == 0: go to DONE; else round <= round - 1 and go to LINV.
- key_sel_o in LINV/SINV/DONE: holds the current round value; must not be relied on.
- DONE:
  - out_valid_o = 1; data_o stable.
  - On out_ready_i: go to IDLE and drop out_valid_o next cycle.
  - Backpressure holds DONE indefinitely with data_o unchanged.
- in_ready_o = 1 only in IDLE. A block arriving in the same cycle DONE is left is not accepted until the following cycle (one idle bubble).
- Latency:
  - Block accepted on edge N; out_valid_o high from edge N+163 (9 rounds × 18 cycles, +1).
  - Throughput: one block per ≥164 cycles.
- in_valid_i while busy is ignored; data_i is sampled only at the accepting edge.

Test Plan:
- GOST known-answer test:
  - Key store loaded with the key expansion of 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef.
  - Spot-check K1 = 8899aabbccddeeff0011223344556677, K10 = 72e9dd7416bcf45b755dbaa88e4a4043; remaining keys from the golden model.
  - data_i = 7f679d90bebc24305a468d42b9d4edcd -> data_o = 1122334455667700ffeeddccbbaa9988, out_valid_o exactly 163 cycles after accept.
- Inverse-primitive checks (force a single-round path by probing st after the LINV and SINV phases of round 9, with K10 = 0):
  - LINV phase: st = d456584dd0e3e84cc3166e4b7fa2890d before LINV -> 64a59400000000000000000000000000 after 16 cycles.
  - SINV phase: st = b66cd8887d38e8d77765aeea0c9a7efc -> ffeeddccbbaa99881122334455667700 after 1 cycle.
- Backpressure: out_ready_i held low 50 cycles after out_valid_o -> data_o and out_valid_o stable, in_ready_o = 0, busy_o = 1; release -> IDLE next cycle.
- Back-to-back: in_valid_i held high with two KAT blocks -> second accepted only after DONE exit plus one bubble; both outputs correct; intermediate in_valid_i pulses ignored.
- Mid-operation reset: drop rst at cycle 80 of a block -> all outputs reach reset values asynchronously; a fresh KAT block afterwards decrypts correctly.
- Key index sequence: monitor key_sel_o in KXOR cycles -> 9 at accept, then 8,7,...,0 in order; exactly 10 key reads per block.
